// File: rtl/vbsme_pkg.sv
// ============================================================================
// vbsme_pkg : shared defaults and helpers for the VBSME thread register store
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package vbsme_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_DEPTH     = 4;

  // Bank index width; a single-bank store still carries a 1-bit index
  function automatic int bank_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // LSB position of a lane inside a packed lane vector
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/thread_reg_row.sv
// ============================================================================
// thread_reg_row : one bank of lane words; shift-then-masked-write next state
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module thread_reg_row
  import vbsme_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          wr_en_i,
  input  logic [NUM_LANES-1:0]          wr_mask_i,
  input  logic [NUM_LANES*DATA_W-1:0]   wr_data_i,
  input  logic                          shift_en_i,
  input  logic [DATA_W-1:0]             shift_in_i,
  output logic [NUM_LANES*DATA_W-1:0]   row_o,
  output logic [NUM_LANES*DATA_W-1:0]   next_o
);

  localparam int VEC_W = NUM_LANES * DATA_W;

  logic [VEC_W-1:0] row_q;
  logic [VEC_W-1:0] row_d;

  // Masked write lanes take priority over the shifted value
  always_comb begin
    row_d = row_q;
    if (shift_en_i) begin
      for (int i = 0; i < NUM_LANES - 1; i++) begin
        row_d[lane_lsb(i, DATA_W) +: DATA_W] = row_q[lane_lsb(i + 1, DATA_W) +: DATA_W];
      end
      row_d[lane_lsb(NUM_LANES - 1, DATA_W) +: DATA_W] = shift_in_i;
    end
    if (wr_en_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_mask_i[i]) begin
          row_d[lane_lsb(i, DATA_W) +: DATA_W] = wr_data_i[lane_lsb(i, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row_o  = row_q;
  assign next_o = row_d;

endmodule

`default_nettype wire

// File: rtl/thread_reg_bank.sv
// ============================================================================
// thread_reg_bank : DEPTH x NUM_LANES register store with masked write,
//                   sliding-window shift and registered read.
// Option macro    : THREAD_REG_BYPASS_EN (same-cycle read sees post-update row)
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module thread_reg_bank
  import vbsme_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DEPTH     = DEF_DEPTH,
  localparam int BANK_W   = bank_w(DEPTH),
  localparam int VEC_W    = NUM_LANES * DATA_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 WrEn,
  input  logic [BANK_W-1:0]    WrBank,
  input  logic [NUM_LANES-1:0] WrMask,
  input  logic [VEC_W-1:0]     WrData,
  input  logic                 ShiftEn,
  input  logic [BANK_W-1:0]    ShiftBank,
  input  logic [DATA_W-1:0]    ShiftIn,
  input  logic                 RdEn,
  input  logic [BANK_W-1:0]    RdBank,
  output logic [VEC_W-1:0]     RdData,
  output logic                 RdValid
);

  logic [VEC_W-1:0] read_src [DEPTH];
  logic [VEC_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  for (genvar b = 0; b < DEPTH; b++) begin : g_bank
    logic [VEC_W-1:0] row;
    logic [VEC_W-1:0] row_next;

    thread_reg_row #(
      .DATA_W    (DATA_W),
      .NUM_LANES (NUM_LANES)
    ) u_row (
      .Clk        (Clk),
      .Reset      (Reset),
      .wr_en_i    (WrEn && (WrBank == BANK_W'(b))),
      .wr_mask_i  (WrMask),
      .wr_data_i  (WrData),
      .shift_en_i (ShiftEn && (ShiftBank == BANK_W'(b))),
      .shift_in_i (ShiftIn),
      .row_o      (row),
      .next_o     (row_next)
    );

`ifdef THREAD_REG_BYPASS_EN
    // next equals the stored row when the bank is idle, so forward it always
    assign read_src[b] = row_next;
`else
    logic unused_row_next;
    assign unused_row_next = ^row_next;
    assign read_src[b]     = row;
`endif
  end

  // Unmatched (out-of-range) bank reads return zero but still report valid
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = RdEn;
    if (RdEn) begin
      rd_data_d = '0;
      for (int b = 0; b < DEPTH; b++) begin
        if (RdBank == BANK_W'(b)) begin
          rd_data_d = read_src[b];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_thread_reg_bank.sv
// ============================================================================
// tb_thread_reg_bank : directed self-checking bench for thread_reg_bank
// Option macro       : THREAD_REG_BYPASS_EN changes same-cycle read expectation
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_thread_reg_bank;

  localparam int DW = 32;
  localparam int NL = 16;
  localparam int VW = NL * DW;
  localparam int BW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          WrEn, ShiftEn, RdEn;
  logic [BW-1:0] WrBank, ShiftBank, RdBank;
  logic [NL-1:0] WrMask;
  logic [VW-1:0] WrData;
  logic [DW-1:0] ShiftIn;
  logic [VW-1:0] RdData;
  logic          RdValid;

  // second instance with a non-power-of-two bank count
  logic          d3_WrEn, d3_RdEn;
  logic [BW-1:0] d3_WrBank, d3_RdBank;
  logic [VW-1:0] d3_WrData;
  logic [VW-1:0] d3_RdData;
  logic          d3_RdValid;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  thread_reg_bank #(.DATA_W(DW), .NUM_LANES(NL), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .WrEn(WrEn), .WrBank(WrBank), .WrMask(WrMask), .WrData(WrData),
    .ShiftEn(ShiftEn), .ShiftBank(ShiftBank), .ShiftIn(ShiftIn),
    .RdEn(RdEn), .RdBank(RdBank), .RdData(RdData), .RdValid(RdValid)
  );

  thread_reg_bank #(.DATA_W(DW), .NUM_LANES(NL), .DEPTH(3)) dut3 (
    .Clk(Clk), .Reset(Reset),
    .WrEn(d3_WrEn), .WrBank(d3_WrBank), .WrMask({NL{1'b1}}), .WrData(d3_WrData),
    .ShiftEn(1'b0), .ShiftBank(2'd0), .ShiftIn({DW{1'b0}}),
    .RdEn(d3_RdEn), .RdBank(d3_RdBank), .RdData(d3_RdData), .RdValid(d3_RdValid)
  );

  function automatic logic [VW-1:0] ramp(input logic [DW-1:0] base);
    logic [VW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = base + DW'(i);
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [DW-1:0] w);
    return {NL{w}};
  endfunction

  task automatic write_bank(input logic [BW-1:0] b, input logic [NL-1:0] m,
                            input logic [VW-1:0] d);
    @(negedge Clk);
    WrEn = 1'b1; WrBank = b; WrMask = m; WrData = d;
    @(posedge Clk); #1;
    WrEn = 1'b0;
  endtask

  task automatic shift_bank(input logic [BW-1:0] b, input logic [DW-1:0] s);
    @(negedge Clk);
    ShiftEn = 1'b1; ShiftBank = b; ShiftIn = s;
    @(posedge Clk); #1;
    ShiftEn = 1'b0;
  endtask

  task automatic read_bank(input logic [BW-1:0] b);
    @(negedge Clk);
    RdEn = 1'b1; RdBank = b;
    @(posedge Clk); #1;
    RdEn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #12;
    checks++;
    if (RdData !== '0) begin failures++; $display("FAIL reset_rddata got=%h exp=0", RdData); end
    checks++;
    if (RdValid !== 1'b0) begin failures++; $display("FAIL reset_rdvalid got=%b exp=0", RdValid); end
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic test_reset_mid_traffic();
    write_bank(2'd1, 16'hFFFF, ramp(32'hA5A5_0000));
    read_bank(2'd1);
    checks++;
    if (RdData !== ramp(32'hA5A5_0000)) begin failures++; $display("FAIL pre_reset_read got=%h exp=%h", RdData, ramp(32'hA5A5_0000)); end
    // keep a shift in flight while reset hits between edges
    ShiftEn = 1'b1; ShiftBank = 2'd1; ShiftIn = 32'h1234;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (RdData !== '0) begin failures++; $display("FAIL async_reset_rddata got=%h exp=0", RdData); end
    checks++;
    if (RdValid !== 1'b0) begin failures++; $display("FAIL async_reset_rdvalid got=%b exp=0", RdValid); end
    ShiftEn = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    read_bank(2'd1);
    checks++;
    if (RdData !== '0) begin failures++; $display("FAIL post_reset_bank1 got=%h exp=0", RdData); end
    checks++;
    if (RdValid !== 1'b1) begin failures++; $display("FAIL post_reset_valid got=%b exp=1", RdValid); end
  endtask

  task automatic test_masked_write();
    logic [VW-1:0] exp_v;
    exp_v = '0;
    exp_v[0*DW +: DW] = 32'd1;
    exp_v[2*DW +: DW] = 32'd3;
    write_bank(2'd2, 16'h0005, ramp(32'd1));
    write_bank(2'd2, 16'h0000, splat(32'hDEAD_BEEF));
    read_bank(2'd2);
    checks++;
    if (RdData !== exp_v) begin failures++; $display("FAIL masked_write got=%h exp=%h", RdData, exp_v); end
    checks++;
    if (RdValid !== 1'b1) begin failures++; $display("FAIL masked_valid got=%b exp=1", RdValid); end
    @(posedge Clk); #1;
    checks++;
    if (RdValid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b exp=0", RdValid); end
    checks++;
    if (RdData !== exp_v) begin failures++; $display("FAIL rddata_hold got=%h exp=%h", RdData, exp_v); end
  endtask

  task automatic test_shift_chain();
    logic [VW-1:0] exp_v;
    exp_v = ramp(32'd3);
    exp_v[13*DW +: DW] = 32'h100;
    exp_v[14*DW +: DW] = 32'h101;
    exp_v[15*DW +: DW] = 32'h102;
    write_bank(2'd0, 16'hFFFF, ramp(32'd0));
    shift_bank(2'd0, 32'h100);
    shift_bank(2'd0, 32'h101);
    shift_bank(2'd0, 32'h102);
    read_bank(2'd0);
    checks++;
    if (RdData !== exp_v) begin failures++; $display("FAIL shift_chain got=%h exp=%h", RdData, exp_v); end
  endtask

  task automatic test_shift_write_same_bank();
    logic [VW-1:0] exp_v;
    exp_v = ramp(32'd1);
    exp_v[0*DW +: DW]  = 32'hEE;
    exp_v[15*DW +: DW] = 32'hEE;
    write_bank(2'd3, 16'hFFFF, ramp(32'd0));
    @(negedge Clk);
    ShiftEn = 1'b1; ShiftBank = 2'd3; ShiftIn = 32'hFF;
    WrEn = 1'b1; WrBank = 2'd3; WrMask = 16'h8001; WrData = splat(32'hEE);
    @(posedge Clk); #1;
    ShiftEn = 1'b0; WrEn = 1'b0;
    read_bank(2'd3);
    checks++;
    if (RdData !== exp_v) begin failures++; $display("FAIL shift_write_same got=%h exp=%h", RdData, exp_v); end
  endtask

  task automatic test_shift_write_diff_banks();
    logic [VW-1:0] exp0, exp2;
    exp0 = ramp(32'd4);
    exp0[12*DW +: DW] = 32'h100;
    exp0[13*DW +: DW] = 32'h101;
    exp0[14*DW +: DW] = 32'h102;
    exp0[15*DW +: DW] = 32'h200;
    exp2 = '0;
    exp2[0*DW +: DW] = 32'd1;
    exp2[1*DW +: DW] = 32'h22;
    exp2[2*DW +: DW] = 32'd3;
    @(negedge Clk);
    ShiftEn = 1'b1; ShiftBank = 2'd0; ShiftIn = 32'h200;
    WrEn = 1'b1; WrBank = 2'd2; WrMask = 16'h0002; WrData = splat(32'h22);
    @(posedge Clk); #1;
    ShiftEn = 1'b0; WrEn = 1'b0;
    read_bank(2'd0);
    checks++;
    if (RdData !== exp0) begin failures++; $display("FAIL diff_bank_shift got=%h exp=%h", RdData, exp0); end
    read_bank(2'd2);
    checks++;
    if (RdData !== exp2) begin failures++; $display("FAIL diff_bank_write got=%h exp=%h", RdData, exp2); end
  endtask

  task automatic test_same_cycle_read();
    logic [VW-1:0] exp_v;
`ifdef THREAD_REG_BYPASS_EN
    exp_v = splat(32'h55);
`else
    exp_v = '0;
`endif
    @(negedge Clk);
    WrEn = 1'b1; WrBank = 2'd1; WrMask = 16'hFFFF; WrData = splat(32'h55);
    RdEn = 1'b1; RdBank = 2'd1;
    @(posedge Clk); #1;
    WrEn = 1'b0; RdEn = 1'b0;
    checks++;
    if (RdData !== exp_v) begin failures++; $display("FAIL same_cycle_read got=%h exp=%h", RdData, exp_v); end
    read_bank(2'd1);
    checks++;
    if (RdData !== splat(32'h55)) begin failures++; $display("FAIL after_write_read got=%h exp=%h", RdData, splat(32'h55)); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] banks [3];
    logic [VW-1:0] exps  [3];
    banks[0] = 2'd1; exps[0] = splat(32'h55);
    banks[1] = 2'd2;
    exps[1] = '0;
    exps[1][0*DW +: DW] = 32'd1;
    exps[1][1*DW +: DW] = 32'h22;
    exps[1][2*DW +: DW] = 32'd3;
    banks[2] = 2'd3;
    exps[2] = ramp(32'd1);
    exps[2][0*DW +: DW]  = 32'hEE;
    exps[2][15*DW +: DW] = 32'hEE;
    @(negedge Clk);
    RdEn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      RdBank = banks[k];
      @(posedge Clk); #1;
      checks++;
      if (RdValid !== 1'b1 || RdData !== exps[k]) begin
        failures++;
        $display("FAIL b2b_read%0d got=%b/%h exp=1/%h", k, RdValid, RdData, exps[k]);
      end
    end
    RdEn = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (RdValid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", RdValid); end
  endtask

  task automatic test_out_of_range();
    logic [VW-1:0] exps [4];
    exps[0] = '0; exps[1] = '0; exps[2] = splat(32'h11); exps[3] = '0;
    @(negedge Clk);
    d3_WrEn = 1'b1; d3_WrBank = 2'd2; d3_WrData = splat(32'h11);
    @(negedge Clk);
    d3_WrBank = 2'd3; d3_WrData = splat(32'h77);
    @(negedge Clk);
    d3_WrEn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      d3_RdEn = 1'b1; d3_RdBank = BW'(k);
      @(posedge Clk); #1;
      d3_RdEn = 1'b0;
      checks++;
      if (d3_RdValid !== 1'b1 || d3_RdData !== exps[k]) begin
        failures++;
        $display("FAIL oob_bank%0d got=%b/%h exp=1/%h", k, d3_RdValid, d3_RdData, exps[k]);
      end
    end
  endtask

  initial begin
    WrEn = 1'b0; WrBank = '0; WrMask = '0; WrData = '0;
    ShiftEn = 1'b0; ShiftBank = '0; ShiftIn = '0;
    RdEn = 1'b0; RdBank = '0;
    d3_WrEn = 1'b0; d3_WrBank = '0; d3_WrData = '0;
    d3_RdEn = 1'b0; d3_RdBank = '0;

    test_reset();
    test_reset_mid_traffic();
    test_masked_write();
    test_shift_chain();
    test_shift_write_same_bank();
    test_shift_write_diff_banks();
    test_same_cycle_read();
    test_back_to_back();
    test_out_of_range();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
